// File: rtl/jtkiwi_vram_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtkiwi_vram_arb_if : client/RAM bus of the VRAM time-slot arbiter        |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface jtkiwi_vram_arb_if #(
  parameter int CLIENTS = 2,
  parameter int AW      = 12,
  parameter int DW      = 16
);
  logic [CLIENTS-1:0]    cl_en;
  logic [CLIENTS*AW-1:0] cl_addr;
  logic [CLIENTS*DW-1:0] cl_data;
  logic [CLIENTS-1:0]    cl_cen;
  logic [AW-1:0]         ram_addr;
  logic [DW-1:0]         ram_q;

  // master: clients plus the RAM read port; slave: the arbiter
  modport master (output cl_en, cl_addr, ram_q, input cl_data, cl_cen, ram_addr);
  modport slave  (input cl_en, cl_addr, ram_q, output cl_data, cl_cen, ram_addr);
endinterface
`default_nettype wire

// File: rtl/jtkiwi_vram_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtkiwi_vram_arb : round-robin slot arbiter for one VRAM read port, plus  |
// | the CPU video config bank with vsync-latched shadow copies.  rev 1.0     |
// +--------------------------------------------------------------------------+
module jtkiwi_vram_arb #(
  parameter int                CLIENTS  = 2,
  parameter int                SLOT_LEN = 2,
  parameter int                AW       = 12,
  parameter int                DW       = 16,
  parameter int                RAM_LAT  = 1,
  parameter int                CFGN     = 4,
  parameter logic [CFGN*8-1:0] CFG_RST  = '0,
  parameter int                SHADOW   = 1
)(
  input  wire logic              rst,
  input  wire logic              clk,
  input  wire logic              hold,
  jtkiwi_vram_arb_if.slave       bus,
  input  wire logic              vs,
  input  wire logic [3:0]        cpu_addr,
  input  wire logic [7:0]        cpu_dout,
  input  wire logic              cfg_cs,
  input  wire logic              cpu_we,
  output logic [7:0]             cpu_din,
  output logic [CFGN*8-1:0]      cfg_out
);

  localparam int c_SW = (CLIENTS  > 1) ? $clog2(CLIENTS)  : 1;
  localparam int c_PW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam logic [c_SW-1:0] c_LAST_SLOT = c_SW'(CLIENTS - 1);
  localparam logic [c_PW-1:0] c_LAST_PH   = c_PW'(SLOT_LEN - 1);

  // data must have come back from the RAM before the end of the slot
  if (SLOT_LEN < RAM_LAT + 1 || RAM_LAT < 1 || RAM_LAT > 2) begin : g_bad_lat
    $error("jtkiwi_vram_arb: SLOT_LEN must be >= RAM_LAT+1 and RAM_LAT in 1..2");
  end

  logic [c_SW-1:0]       r_slot;
  logic [c_PW-1:0]       r_phase;
  logic [CLIENTS-1:0]    r_cen;
  logic [CLIENTS*DW-1:0] r_data;
  logic                  w_last_ph;

  assign w_last_ph    = (r_phase == c_LAST_PH);
  assign bus.ram_addr = bus.cl_addr[r_slot*AW +: AW];
  assign bus.cl_cen   = r_cen;
  assign bus.cl_data  = r_data;

  // slot counter kept as (slot, phase) so no divider is needed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot  <= '0;
      r_phase <= '0;
      r_cen   <= '0;
      r_data  <= '0;
    end else if (hold) begin
      r_cen <= '0;
    end else begin
      r_cen <= '0;
      if (w_last_ph) begin
        r_phase <= '0;
        r_slot  <= (r_slot == c_LAST_SLOT) ? '0 : r_slot + 1'b1;
        if (bus.cl_en[r_slot]) begin
          r_cen[r_slot]           <= 1'b1;
          r_data[r_slot*DW +: DW] <= bus.ram_q;
        end
      end else begin
        r_phase <= r_phase + 1'b1;
      end
    end
  end

  logic [CFGN*8-1:0] r_live;
  logic [CFGN*8-1:0] r_shadow;
  logic [3:0]        w_idx;
  logic              r_vs;
  logic              r_rise;

  assign w_idx   = cpu_addr & 4'(CFGN - 1);
  assign cpu_din = cfg_cs ? r_live[w_idx*8 +: 8] : 8'd0;
  assign cfg_out = (SHADOW != 0) ? r_shadow : r_live;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live <= CFG_RST;
    end else if (cfg_cs && cpu_we) begin
      r_live[w_idx*8 +: 8] <= cpu_dout;
    end
  end

  // shadow loads one cycle after the detected rise, so a write on the
  // load edge itself only lands at the following frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs     <= 1'b0;
      r_rise   <= 1'b0;
      r_shadow <= CFG_RST;
    end else begin
      r_vs   <= vs;
      r_rise <= vs & ~r_vs;
      if (r_rise) r_shadow <= r_live;
    end
  end

endmodule
`default_nettype wire
